// File: rtl/mod_add_pipe.sv
// Two-stage pipelined modular add/sub/accumulate unit with a shared advance enable.
// Stage 1 registers the raw WIDTH+1 bit sum; stage 2 reduces it modulo MODULUS.
module mod_add_pipe #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_wrap,
   output logic             out_err,
   output logic [WIDTH-1:0] acc_value
);

   generate
      if ((WIDTH < 2) || (MODULUS < 2) || (longint'(MODULUS) > (longint'(1) << WIDTH))) begin : g_bad_param
         $error("mod_add_pipe: MODULUS must lie in 2..2**WIDTH and WIDTH must be >= 2");
      end
   endgenerate

   localparam logic [WIDTH:0] M = (WIDTH+1)'(MODULUS);

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_ACC = 2'b10,
      OP_CLR = 2'b11
   } op_t;

   logic             r_s1_valid;
   op_t              r_s1_op;
   logic             r_s1_err;
   logic [WIDTH:0]   r_s1_sum;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_wrap;
   logic             r_out_err;
   logic [WIDTH-1:0] r_acc;

   logic             w_en;
   op_t              w_op;
   logic [WIDTH:0]   w_a;
   logic [WIDTH:0]   w_b;
   logic             w_a_bad;
   logic             w_b_bad;
   logic             w_err;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_acc_next;
   logic             w_s1_ge;
   logic [WIDTH:0]   w_s1_red;
   logic             w_s1_wrap;

   // Both stages and the accumulator advance together; a stalled output freezes everything.
   assign w_en     = !r_out_valid || out_ready;
   assign in_ready = w_en;

   assign w_op    = op_t'(in_op);
   assign w_a     = {1'b0, in_a};
   assign w_b     = {1'b0, in_b};
   assign w_a_bad = (w_a >= M);
   assign w_b_bad = (w_b >= M);

   always_comb begin
      w_err = 1'b0;
      w_sum = '0;
      case (w_op)
         OP_ADD: begin
            w_err = w_a_bad || w_b_bad;
            if (!w_err) w_sum = w_a + w_b;
         end
         OP_SUB: begin
            w_err = w_a_bad || w_b_bad;
            if (!w_err) w_sum = w_a + (M - w_b);
         end
         OP_ACC: begin
            w_err = w_a_bad;
            if (!w_err) w_sum = w_a + {1'b0, r_acc};
         end
         default: begin
            w_err = 1'b0;
            w_sum = '0;
         end
      endcase
   end

   assign w_acc_next = (w_sum >= M) ? (w_sum - M) : w_sum;

   // SUB adds M - b, so the sum falls below M exactly when a borrow occurred.
   assign w_s1_ge   = (r_s1_sum >= M);
   assign w_s1_red  = w_s1_ge ? (r_s1_sum - M) : r_s1_sum;
   assign w_s1_wrap = (r_s1_op == OP_SUB) ? !w_s1_ge :
                      (r_s1_op == OP_CLR) ? 1'b0 : w_s1_ge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_op     <= OP_ADD;
         r_s1_err    <= 1'b0;
         r_s1_sum    <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_wrap  <= 1'b0;
         r_out_err   <= 1'b0;
         r_acc       <= '0;
      end else if (w_en) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_op  <= w_op;
            r_s1_err <= w_err;
            r_s1_sum <= w_sum;
            if (w_op == OP_CLR) begin
               r_acc <= '0;
            end else if ((w_op == OP_ACC) && !w_err) begin
               r_acc <= w_acc_next[WIDTH-1:0];
            end
         end
         r_out_valid <= r_s1_valid;
         if (r_s1_valid && !r_s1_err) begin
            r_out_data <= w_s1_red[WIDTH-1:0];
            r_out_wrap <= w_s1_wrap;
            r_out_err  <= 1'b0;
         end else begin
            r_out_data <= '0;
            r_out_wrap <= 1'b0;
            r_out_err  <= r_s1_valid && r_s1_err;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_wrap  = r_out_wrap;
   assign out_err   = r_out_err;
   assign acc_value = r_acc;

endmodule

// File: tb/tb_mod_add_pipe.sv
// Bench for mod_add_pipe: three instances (M=16, 10, 15) run in lockstep on one stimulus
// stream; a reference model fills an expected queue that a monitor drains.
module tb_mod_add_pipe;

   localparam int W = 4;
   localparam int N = 3;
   localparam int MODS[N] = '{16, 10, 15};
   localparam int EW = W + 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [1:0]   in_op = '0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_ready[N];
   logic         out_valid[N];
   logic         out_wrap[N];
   logic         out_err[N];
   logic [W-1:0] out_data[N];
   logic [W-1:0] acc_value[N];

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_dut
         mod_add_pipe #(.WIDTH(W), .MODULUS(MODS[g])) u_dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid), .in_ready(in_ready[g]), .in_op(in_op),
            .in_a(in_a), .in_b(in_b),
            .out_valid(out_valid[g]), .out_ready(out_ready),
            .out_data(out_data[g]), .out_wrap(out_wrap[g]), .out_err(out_err[g]),
            .acc_value(acc_value[g])
         );
      end
   endgenerate

   int checks = 0;
   int errors = 0;
   logic [N*EW-1:0] exp_q[$];
   int acc_m[N];
   int stall_left = 0;
   bit rand_bp = 1'b0;

   task automatic check(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: modular arithmetic straight from the operation rules; returns {err, wrap, data}.
   function automatic logic [EW-1:0] ref_op(int idx, int op, int a, int b);
      int m = MODS[idx];
      int s;
      case (op)
         0: begin
            if (a >= m || b >= m) return {2'b10, W'(0)};
            s = a + b;
            return {1'b0, s >= m, W'(s % m)};
         end
         1: begin
            if (a >= m || b >= m) return {2'b10, W'(0)};
            return {1'b0, a < b, W'((a - b + m) % m)};
         end
         2: begin
            if (a >= m) return {2'b10, W'(0)};
            s = a + acc_m[idx];
            acc_m[idx] = s % m;
            return {1'b0, s >= m, W'(acc_m[idx])};
         end
         default: begin
            acc_m[idx] = 0;
            return '0;
         end
      endcase
   endfunction

   task automatic drive_ready();
      if (stall_left > 0) begin
         out_ready = 1'b0;
         stall_left--;
      end else if (rand_bp) begin
         out_ready = ($urandom_range(0, 3) != 0);
      end else begin
         out_ready = 1'b1;
      end
   endtask

   task automatic send(int op, int a, int b);
      bit done = 1'b0;
      logic [N*EW-1:0] e;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         drive_ready();
         in_valid = 1'b1;
         in_op = 2'(op);
         in_a = W'(a);
         in_b = W'(b);
         #1;
         if (in_ready[0]) begin
            for (int i = 0; i < N; i++) e[i*EW +: EW] = ref_op(i, op, a, b);
            exp_q.push_back(e);
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready stayed 0, required 1 within 200 cycles");
      end
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         drive_ready();
         in_valid = 1'b0;
      end
   endtask

   task automatic check_acc();
      for (int i = 0; i < N; i++) check($sformatf("acc_m%0d", MODS[i]), acc_value[i], acc_m[i]);
   endtask

   // Monitor: handshakes complete at the next rising edge, so sample late in the low phase.
   bit prev_stall = 1'b0;
   logic [N*EW-1:0] prev_out;
   logic [N*EW-1:0] cur_out;
   logic [N*EW-1:0] exp_e;
   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         for (int i = 0; i < N; i++) cur_out[i*EW +: EW] = {out_err[i], out_wrap[i], out_data[i]};
         if (prev_stall) begin
            check("stall_valid", out_valid[0], 1);
            check("stall_hold", cur_out, prev_out);
         end
         if (out_valid[0] && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got out_valid=1, required no pending result");
            end else begin
               exp_e = exp_q.pop_front();
               for (int i = 0; i < N; i++) begin
                  check($sformatf("valid_m%0d", MODS[i]), out_valid[i], 1);
                  check($sformatf("result_m%0d", MODS[i]), cur_out[i*EW +: EW], exp_e[i*EW +: EW]);
               end
            end
         end
         if (out_valid[0] && !out_ready) begin
            check("stall_in_ready", in_ready[0], 0);
            prev_stall = 1'b1;
            prev_out = cur_out;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   initial begin
      acc_m = '{default: 0};
      #3;
      for (int i = 0; i < N; i++) begin
         check("rst_valid", out_valid[i], 0);
         check("rst_data", out_data[i], 0);
         check("rst_acc", acc_value[i], 0);
         check("rst_in_ready", in_ready[i], 1);
      end
      @(negedge clk);
      rst_n = 1'b1;

      send(0, 9, 9);
      send(0, 3, 4);
      send(1, 3, 7);
      send(1, 7, 3);
      send(0, 12, 1);
      send(3, 0, 0);
      send(2, 7, 0);
      send(2, 5, 3);
      send(2, 9, 12);
      idle(1);
      #1;
      check_acc();
      check("acc_m10_value", acc_value[1], 1);
      send(2, 11, 4);
      idle(1);
      #1;
      check_acc();
      check("acc_m10_after_err", acc_value[1], 1);

      send(0, 15, 0);
      send(0, 14, 1);

      send(0, 1, 2);
      send(0, 5, 6);
      stall_left = 3;
      send(0, 8, 8);
      send(0, 15, 15);
      idle(6);

      send(2, 5, 0);
      send(2, 6, 0);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      #3;
      rst_n = 1'b0;
      exp_q.delete();
      acc_m = '{default: 0};
      #1;
      for (int i = 0; i < N; i++) begin
         check("async_rst_valid", out_valid[i], 0);
         check("async_rst_data", out_data[i], 0);
         check("async_rst_flags", {out_wrap[i], out_err[i]}, 0);
         check("async_rst_acc", acc_value[i], 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", in_ready[0], 1);

      send(0, 2, 3);
      @(negedge clk);
      in_valid = 1'b0;
      drive_ready();
      #1;
      check("latency_early", out_valid[0], 0);
      @(negedge clk);
      drive_ready();
      #1;
      check("latency_on_time", out_valid[0], 1);

      rand_bp = 1'b1;
      repeat (300) begin
         send($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15));
         if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
      end
      rand_bp = 1'b0;
      for (int t = 0; t < 200 && exp_q.size() != 0; t++) idle(1);
      check("drain_empty", exp_q.size(), 0);
      idle(3);
      check_acc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mod_add_pipe.md
# mod_add_pipe

Parametrised, two-stage pipelined modular arithmetic unit with an internal modular accumulator and valid/ready handshakes on both sides. It generalises the 4-bit registered mod-16 adder to any width and any modulus 2..2^WIDTH. It adds modular subtract, accumulate and clear operations, wrap and range-error flags, and back-pressure. It sits between an operand producer and a result consumer in the datapath.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- MODULUS, 16, modulus M; legal range 2..2^WIDTH; elaboration fails outside it

- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand transfer request
- in_ready  out  1  unit can accept; transfer when in_valid & in_ready
- in_op  in  2  00 ADD, 01 SUB, 10 ACC, 11 CLR
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B (ignored for ACC/CLR)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts; transfer when out_valid & out_ready
- out_data  out  WIDTH  result, always < M
- out_wrap  out  1  modular wrap occurred
- out_err  out  1  operand out of range (≥ M)
- acc_value  out  WIDTH  current accumulator contents

## Operation
- Internal sums are WIDTH+1 bits; M is held in WIDTH+1 bits; no intermediate overflow.
- Stage 1 (on acceptance) registers op, error flag and raw sum R:
  - ADD: R = a + b
  - SUB: R = a + (M − b)
  - ACC: R = a + acc; acc ← (a + acc) mod M, updated in the same edge, so back-to-back ACC ops chain correctly
  - CLR: R = 0; acc ← 0
- Stage 2 reduces: if R ≥ M then data = R − M else data = R. For inputs < M, R < 2M, so one conditional subtract is exact.
- Wrap flag:
  - ADD/ACC: 1 when a + b (or a + acc) ≥ M.
  - SUB: 1 when a < b, i.e. borrow.
  - CLR: 0.
- Error: in ADD/SUB, any operand ≥ M sets out_err=1, out_data=0, out_wrap=0. In ACC, a ≥ M sets the same and acc is unchanged. CLR never errors.
- Range check uses only the operands the op consumes; in_b is ignored for ACC/CLR.

## Timing
- Global advance enable: en = !out_valid | out_ready; in_ready = en; both stages move only when en=1.
- Latency: an operand accepted at edge N produces out_valid=1 after edge N+1, at the earliest.
- Throughput: one op per cycle with out_ready held high.
- Stall: while out_valid & !out_ready, out_data/out_wrap/out_err and stage-1 contents hold; in_ready=0; acc does not change.
- Bubbles: in_valid=0 while en=1 shifts an empty slot through; out_valid deasserts accordingly.
- Simultaneous pop and push in the same cycle is legal and loses nothing.
- Reset (any time, including mid-stall) clears everything immediately:
  - out_valid=0, out_data=0, out_wrap=0, out_err=0
  - acc=0, both stage valid bits 0
  - in_ready=1 once rst_n is high
- Results in flight are discarded on reset.
- in_ready depends combinationally on out_ready. No other combinational input-to-output path.

## Test plan
- M=16, W=4, out_ready=1: ADD 9+9 → out_data=2, wrap=1, two edges after acceptance. ADD 3+4 → 7, wrap=0.
- M=10, W=4: SUB 3−7 → 6, wrap=1. SUB 7−3 → 4, wrap=0. ADD 12+1 → data 0, err=1.
- M=10: CLR, then ACC 7, ACC 5, ACC 9 back-to-back → outputs 7, 2(wrap), 1(wrap); acc_value=1. ACC 11 → err=1, acc stays 1.
- Back-pressure: stream 4 ADDs with out_ready low for 3 cycles mid-stream. Required: in_ready=0 during the stall, held output stable, all 4 results delivered in order, no duplicates.
- Async reset asserted between clock edges with 2 ops in flight: outputs and acc_value go to 0 without a clock edge. First op after release emerges with the normal 2-cycle latency.
- M=2^WIDTH=16 versus M=15 boundary: ADD 15+0 → 15 for M=16, err for M=15. ADD 14+1 with M=15 → 0, wrap=1.
